up_ramcfg_rdarb2: RTL and testbench
===================================

# up_ramcfg_rdarb2

Two-requester read arbiter and scheduler for the engine read port of a configuration RAM macro (1 engine read port, 2-cycle read latency, CPU reads wait while the engine port is busy). It shares the single engine port between two engine requesters using round-robin. It returns data with a per-requester valid aligned to the macro's clk-2 data. A starvation guard inserts idle engine slots so a waiting CPU read can complete.

## Interface
Parameters:
- G_ADDR, 10, address width.
- G_WIDTH, 32, data width.
- G_STARVE, 8, max consecutive granted engine cycles while a CPU read is pending; 0 disables the guard.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_re  in  1  requester 0 read request; held with req0_ra until granted.
- req0_ra  in  G_ADDR  requester 0 read address.
- req0_gnt  out  1  requester 0 granted this cycle (combinational).
- req0_vld  out  1  requester 0 read data valid (clk 2 after grant).
- req0_rdd  out  G_WIDTH  requester 0 read data.
- req1_re, req1_ra, req1_gnt, req1_vld, req1_rdd: same as requester 0, for requester 1.
- upen  in  1  CPU bus enable (monitor only).
- uprs  in  1  CPU read strobe (monitor only).
- uprdy  in  1  CPU ready from the RAM macro (monitor only).
- oeng_re  out  1  to macro engine read enable.
- oeng_ra  out  G_ADDR  to macro engine read address.
- ieng_rdd  in  G_WIDTH  from macro engine read data (clk 2).

## Operation
- cpu_pend = upen & uprs & !uprdy (combinational).
- idle_slot = (G_STARVE != 0) & cpu_pend & (stv_cnt == G_STARVE). It forces no grant this cycle.
- Round-robin pointer `last` (1 bit, reset 1, so requester 0 wins the first contention):
  - Only req0_re → gnt0.
  - Only req1_re → gnt1.
  - Both → grant the requester != last.
  - None, or idle_slot → no grant.
- `last` updates to the granted index on any grant. It holds otherwise.
- oeng_re = gnt0 | gnt1; oeng_ra = gnt1 ? req1_ra : req0_ra.
- Starvation counter stv_cnt (width ≥ clog2(G_STARVE+1), reset 0):
  - Increments on a granted cycle while cpu_pend.
  - Clears on an idle_slot, on any cycle with !cpu_pend, or on a non-granted cycle.
  - Saturates at G_STARVE.
- Return tag pipeline: two stages of {gnt0, gnt1}, reset 0.
  - reqN_vld = stage-2 gntN.
  - req0_rdd = req1_rdd = ieng_rdd, passed through ungated; consumers qualify with vld.
- Requester rule: reqN_re and reqN_ra must stay stable until gntN. Changing them before grant is illegal, and the arbiter does not check it.
- A requester may keep re high after a grant to issue back-to-back reads. Each grant is one read.

## Timing
- Cycle 0: gnt, oeng_re and oeng_ra are all combinational from the requests.
- Cycle 2: reqN_vld = 1 for exactly one cycle per grant, aligned with the macro's ieng_rdd.
- Throughput: one read per cycle total.
  - Under contention, grants alternate 0,1,0,1.
  - A single requester streams every cycle.
- Idle slot: exactly one non-granted cycle after G_STARVE consecutive grants with cpu_pend. The macro then accepts the CPU read, since its engine re is low.
- Reset values: req0_gnt = req1_gnt = 0 when no request; req0_vld = req1_vld = 0; oeng_re follows grants; last = 1; stv_cnt = 0.
- Reset mid-operation: assertion clears the tag pipeline asynchronously. In-flight reads are dropped, and no vld appears after reset release.
- Simultaneous request and idle_slot: the idle slot wins. Both requests wait and `last` is unchanged.
- The pointer does not wrap; the counter saturates.

## Test plan
- Reset release, req0_re = 1 with ra = 0x005 for one cycle → gnt0 in cycle 0, oeng_ra = 0x005, req0_vld in cycle 2 with req0_rdd = memory[0x005]; req1_vld stays 0.
- req0 and req1 held continuously, ra 0x010 and 0x020 → grants in order 0,1,0,1,…; vld pulses alternate 2 cycles later; data matches the respective addresses.
- G_STARVE = 4, req0 streaming, CPU read of 0x030 pending → 4 grants, then 1 idle cycle, CPU uprdy 2 cycles later with updo = memory[0x030]; grants then resume.
- G_STARVE = 0, same stimulus → no idle slot; grant every cycle; CPU waits until req0 drops.
- Both requests issued, rst_n pulled low in cycle 1 → req0_vld and req1_vld are never asserted; after release the first contention grants req0.
- req1 alone 3 cycles, then both request → the first contended grant goes to req0 (last = 1).

Source files
------------

// File: rtl/up_ramcfg_rdarb2.sv
// Round-robin arbiter sharing the RAM macro engine read port between two requesters,
// with a 2-cycle return tag pipeline and a starvation guard that opens idle slots for CPU reads.
module up_ramcfg_rdarb2 #(
  parameter int G_ADDR   = 10,
  parameter int G_WIDTH  = 32,
  parameter int G_STARVE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_re,
  input  logic [G_ADDR-1:0]  req0_ra,
  output logic               req0_gnt,
  output logic               req0_vld,
  output logic [G_WIDTH-1:0] req0_rdd,
  input  logic               req1_re,
  input  logic [G_ADDR-1:0]  req1_ra,
  output logic               req1_gnt,
  output logic               req1_vld,
  output logic [G_WIDTH-1:0] req1_rdd,
  input  logic               upen,
  input  logic               uprs,
  input  logic               uprdy,
  output logic               oeng_re,
  output logic [G_ADDR-1:0]  oeng_ra,
  input  logic [G_WIDTH-1:0] ieng_rdd
);

  localparam int            CW        = (G_STARVE < 1) ? 1 : $clog2(G_STARVE + 1);
  localparam logic [CW-1:0] STV_MAX   = CW'(G_STARVE);
  localparam logic          STARVE_EN = (G_STARVE != 0);

  logic          cpuPend;
  logic          idleSlot;
  logic          grant0;
  logic          grant1;
  logic          anyGrant;
  logic          last_q,   last_d;
  logic [CW-1:0] stvCnt_q, stvCnt_d;
  logic [1:0]    tagS1_q,  tagS2_q;

  assign cpuPend  = upen & uprs & ~uprdy;
  assign idleSlot = STARVE_EN & cpuPend & (stvCnt_q == STV_MAX);

  // Under contention the requester that was not granted last wins; an idle slot blocks both.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!idleSlot) begin
      if (req0_re && req1_re) begin
        grant0 = last_q;
        grant1 = ~last_q;
      end else begin
        grant0 = req0_re;
        grant1 = req1_re;
      end
    end
  end

  assign anyGrant = grant0 | grant1;
  assign last_d   = anyGrant ? grant1 : last_q;

  // Count back-to-back engine grants seen by a waiting CPU read, saturating at the limit.
  always_comb begin
    stvCnt_d = stvCnt_q;
    if (idleSlot || !cpuPend || !anyGrant) begin
      stvCnt_d = '0;
    end else if (stvCnt_q != STV_MAX) begin
      stvCnt_d = stvCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= 1'b1;
      stvCnt_q <= '0;
      tagS1_q  <= 2'b00;
      tagS2_q  <= 2'b00;
    end else begin
      last_q   <= last_d;
      stvCnt_q <= stvCnt_d;
      tagS1_q  <= {grant0, grant1};
      tagS2_q  <= tagS1_q;
    end
  end

  assign req0_gnt = grant0;
  assign req1_gnt = grant1;
  assign oeng_re  = anyGrant;
  assign oeng_ra  = grant1 ? req1_ra : req0_ra;

  // Tag stage 2 lines up with the macro's read data two cycles after the grant.
  assign req0_vld = tagS2_q[1];
  assign req1_vld = tagS2_q[0];
  assign req0_rdd = ieng_rdd;
  assign req1_rdd = ieng_rdd;

endmodule

// File: tb/tb_up_ramcfg_rdarb2.sv
// Directed bench for up_ramcfg_rdarb2: a 2-cycle macro model per instance feeds the read data,
// and expected grants are hand-written per cycle, with expected valids derived from them.
module tb_up_ramcfg_rdarb2;

  logic        clk;
  logic        rst_n;
  logic        req0_re, req1_re;
  logic [9:0]  req0_ra, req1_ra;
  logic        upen, uprs, uprdy;

  logic        req0_gnt, req1_gnt, req0_vld, req1_vld, oeng_re;
  logic [31:0] req0_rdd, req1_rdd, ieng_rdd;
  logic [9:0]  oeng_ra;

  logic        nsReq0Gnt, nsReq1Gnt, nsReq0Vld, nsReq1Vld, nsOengRe;
  logic [31:0] nsReq0Rdd, nsReq1Rdd, nsIengRdd;
  logic [9:0]  nsOengRa;

  int checkCount = 0;
  int errorCount = 0;

  logic [1:0]  histG0, histG1;
  logic [9:0]  histA [2];
  logic [9:0]  macA1, macA2, nsMacA1, nsMacA2;

  up_ramcfg_rdarb2 #(.G_ADDR(10), .G_WIDTH(32), .G_STARVE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_re(req0_re), .req0_ra(req0_ra), .req0_gnt(req0_gnt), .req0_vld(req0_vld), .req0_rdd(req0_rdd),
    .req1_re(req1_re), .req1_ra(req1_ra), .req1_gnt(req1_gnt), .req1_vld(req1_vld), .req1_rdd(req1_rdd),
    .upen(upen), .uprs(uprs), .uprdy(uprdy),
    .oeng_re(oeng_re), .oeng_ra(oeng_ra), .ieng_rdd(ieng_rdd)
  );

  up_ramcfg_rdarb2 #(.G_ADDR(10), .G_WIDTH(32), .G_STARVE(0)) dutNoStarve (
    .clk(clk), .rst_n(rst_n),
    .req0_re(req0_re), .req0_ra(req0_ra), .req0_gnt(nsReq0Gnt), .req0_vld(nsReq0Vld), .req0_rdd(nsReq0Rdd),
    .req1_re(req1_re), .req1_ra(req1_ra), .req1_gnt(nsReq1Gnt), .req1_vld(nsReq1Vld), .req1_rdd(nsReq1Rdd),
    .upen(upen), .uprs(uprs), .uprdy(uprdy),
    .oeng_re(nsOengRe), .oeng_ra(nsOengRa), .ieng_rdd(nsIengRdd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memFn(input logic [9:0] a);
    return 32'hC0DE0000 | {22'd0, a};
  endfunction

  // Macro engine port model: address captured at the grant edge, data presented two cycles on.
  always @(posedge clk) begin
    macA1   <= oeng_ra;
    macA2   <= macA1;
    nsMacA1 <= nsOengRa;
    nsMacA2 <= nsMacA1;
  end
  assign ieng_rdd  = memFn(macA2);
  assign nsIengRdd = memFn(nsMacA2);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic clearHistory();
    histG0   = 2'b00;
    histG1   = 2'b00;
    histA[0] = '0;
    histA[1] = '0;
  endtask

  // One cycle: drive inputs after the falling edge, check mid-cycle, then record the expected grant.
  task automatic applyStimulus(input logic r0, input logic r1, input logic [9:0] a0, input logic [9:0] a1,
                               input logic pend, input logic rdy, input logic eg0, input logic eg1);
    @(negedge clk);
    req0_re = r0; req1_re = r1; req0_ra = a0; req1_ra = a1;
    upen = pend | rdy; uprs = pend | rdy; uprdy = rdy;
    #2;
    checkOutput("gnt0", {31'd0, req0_gnt}, {31'd0, eg0});
    checkOutput("gnt1", {31'd0, req1_gnt}, {31'd0, eg1});
    checkOutput("oeng_re", {31'd0, oeng_re}, {31'd0, eg0 | eg1});
    if (eg0 | eg1) checkOutput("oeng_ra", {22'd0, oeng_ra}, {22'd0, eg1 ? a1 : a0});
    checkOutput("vld0", {31'd0, req0_vld}, {31'd0, histG0[1]});
    checkOutput("vld1", {31'd0, req1_vld}, {31'd0, histG1[1]});
    if (histG0[1]) checkOutput("rdd0", req0_rdd, memFn(histA[1]));
    if (histG1[1]) checkOutput("rdd1", req1_rdd, memFn(histA[1]));
    histG0   = {histG0[0], eg0};
    histG1   = {histG1[0], eg1};
    histA[1] = histA[0];
    histA[0] = eg1 ? a1 : a0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_re = 1'b0; req1_re = 1'b0; upen = 1'b0; uprs = 1'b0; uprdy = 1'b0;
    #2;
    checkOutput("rst_vld0", {31'd0, req0_vld}, 32'd0);
    checkOutput("rst_vld1", {31'd0, req1_vld}, 32'd0);
    checkOutput("rst_gnt0", {31'd0, req0_gnt}, 32'd0);
    checkOutput("rst_oeng_re", {31'd0, oeng_re}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clearHistory();
  endtask

  initial begin
    rst_n = 1'b0;
    req0_re = 1'b0; req1_re = 1'b0; req0_ra = '0; req1_ra = '0;
    upen = 1'b0; uprs = 1'b0; uprdy = 1'b0;
    clearHistory();
    repeat (2) @(posedge clk);

    // Single read after reset release
    doReset();
    applyStimulus(1'b1, 1'b0, 10'h005, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) idleCycle();

    // Continuous contention alternates starting with requester 0
    doReset();
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 1'b1, 10'h010, 10'h020, 1'b0, 1'b0, (i % 2) == 0, (i % 2) == 1);
    repeat (3) idleCycle();

    // Starvation guard: four grants, one idle slot, CPU done two cycles later
    doReset();
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b0, 10'h040, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 10'h040, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 10'h041, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 10'h042, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 10'h043, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) idleCycle();

    // Guard disabled: the instance without a limit grants every cycle despite a pending CPU read
    doReset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req0_re = 1'b1; req0_ra = 10'h050; upen = 1'b1; uprs = 1'b1; uprdy = 1'b0;
      #2;
      checkOutput("ns_gnt0", {31'd0, nsReq0Gnt}, 32'd1);
      checkOutput("ns_oeng_re", {31'd0, nsOengRe}, 32'd1);
    end
    @(negedge clk);
    req0_re = 1'b0;
    #2;
    checkOutput("ns_gnt0_drop", {31'd0, nsReq0Gnt}, 32'd0);
    checkOutput("ns_oeng_re_drop", {31'd0, nsOengRe}, 32'd0);
    upen = 1'b0; uprs = 1'b0;

    // Reset during cycle 1 drops in-flight reads; first contention afterwards goes to requester 0
    doReset();
    applyStimulus(1'b1, 1'b1, 10'h060, 10'h070, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 10'h060, 10'h070, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    clearHistory();
    idleCycle();
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    checkOutput("post_rst_vld0", {31'd0, req0_vld}, 32'd0);
    checkOutput("post_rst_vld1", {31'd0, req1_vld}, 32'd0);
    repeat (3) idleCycle();
    applyStimulus(1'b1, 1'b1, 10'h061, 10'h071, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 10'h061, 10'h071, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) idleCycle();

    // Requester 1 alone, then contention: requester 0 wins because requester 1 went last
    doReset();
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b1, 10'h000, 10'h080 + 10'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 10'h090, 10'h083, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 10'h091, 10'h083, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) idleCycle();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
